sync_fifo_fwft: RTL and testbench
=================================

// Module: sync_fifo_fwft
// PURPOSE
//  Parametrised single-clock FIFO for valid/ready streams. Succeeds the fixed 33b x 1024 sync FIFO.
//  Adds first-word-fall-through output, true occupancy count, almost-full/empty flags and sync flush.
//  Sits between an upstream producer and a downstream consumer on the same clock domain.
// PARAMETERS
//  WIDTH      33    data word width in bits (>=1)
//  DEPTH      1024  entry count; power of two, >=2
//  AF_THRESH  DEPTH-2  almost_full asserts when count >= AF_THRESH
//  AE_THRESH  1     almost_empty asserts when count <= AE_THRESH
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          synchronous reset, active-high
//  flush            in   1          synchronous clear of contents, active-high
//  upstr_d_valid    in   1          producer has a word
//  upstr_data       in   WIDTH      producer word
//  upstr_d_ready    out  1          FIFO can accept (= ~full)
//  downstr_d_valid  out  1          head word present on downstr_data
//  downstr_data     out  WIDTH      head word, registered
//  downstr_d_ready  in   1          consumer takes head word
//  count            out  CW         occupancy 0..DEPTH, CW = clog2(DEPTH)+1
//  almost_full      out  1          count >= AF_THRESH
//  almost_empty     out  1          count <= AE_THRESH
// BEHAVIOUR
//  - push = upstr_d_valid & upstr_d_ready; pop = downstr_d_valid & downstr_d_ready.
//  - Reset (rst=1 at edge): pointers=0, count=0, upstr_d_ready=1, downstr_d_valid=0,
//    downstr_data=0, almost_full=(AF_THRESH==0), almost_empty=1. Overrides flush and traffic.
//  - Flush: same result as reset except downstr_data keeps its value. Flush beats push/pop
//    in the same cycle: the word offered that cycle is dropped.
//  - All outputs registered; no combinational path from any input to any output.
//  - Pointers: ADDR_W+1 bits (extra wrap bit); full = addresses equal and wrap bits differ;
//    empty = pointers equal. Wrap from DEPTH-1 to 0 is natural binary roll-over.
//  - count includes the word held in the output register. push-only +1, pop-only -1, both 0.
//  - FWFT latency: push into empty FIFO at edge N -> downstr_d_valid=1 with that word after N+1.
//  - Pop with further words stored -> next word valid the following cycle; no bubble;
//    sustained 1 word/clk when both sides are ready.
//  - Full (count==DEPTH): upstr_d_ready=0; a pop in the same cycle does not admit a push.
//    Ready returns the cycle after the pop.
//  - Empty: downstr_d_valid=0; downstr_data holds the last value. Simultaneous push on empty
//    is accepted; the word appears next cycle.
//  - downstr_data and downstr_d_valid stay stable while valid & ~ready (AXI-style hold).
//  - Overflow and underflow are impossible by construction; the storage write enable is push only.
//  - almost_full/almost_empty are computed from count_next and registered with count.
// STRUCTURE
//  - Shared package fifo_pkg: clog2 function, default WIDTH/DEPTH constants, CW derivation.
//  - One sub-module, fifo_ram_2p: WIDTH x DEPTH simple dual-port array, 1 write port,
//    1 registered read port, no reset on storage.
//  - Top holds pointers, count, flags and the FWFT prefetch/output-register control.
// TESTING  (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless noted)
//  1. Reset, then push 0xA1 with downstr_d_ready=0 -> valid=1, data=0xA1 after one edge;
//     count=1, almost_empty=1.
//  2. Push 0x01..0x04, no pop -> count=4, upstr_d_ready=0, almost_full=1 from count 3;
//     a 5th valid is held off.
//  3. Full, pop and offer 0x05 in the same cycle -> 0x05 not accepted, count=3;
//     ready=1 next cycle, 0x05 accepted next.
//  4. Both sides always ready, stream 0x00..0x0F -> output identical order, 1 word/clk
//     after the first, count never >1, pointers wrap 4 times.
//  5. Count=3, flush=1 with push 0x77 -> count=0, valid=0, ready=1, 0x77 never emitted;
//     a later push of 0x88 emerges first.
//  6. Mid-stream rst=1 for 1 cycle with valid=1 -> all outputs at reset values next cycle;
//     default params (33x1024) fill to 1024 -> ready=0, count=1024.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FWFT FIFO and its storage array.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 33;
    localparam int unsigned DEF_DEPTH = 1024;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy counter must reach DEPTH itself, hence one bit beyond the address.
    function automatic int unsigned count_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write-first read: a same-edge write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost flags and flush.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          upstr_d_valid,
    input  logic [WIDTH-1:0]              upstr_data,
    output logic                          upstr_d_ready,
    output logic                          downstr_d_valid,
    output logic [WIDTH-1:0]              downstr_data,
    input  logic                          downstr_d_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          almost_full,
    output logic                          almost_empty
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned PW     = ADDR_W + 1;
    localparam int unsigned CW     = count_width(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  ram_rdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic              push;
    logic              pop;

    // Every word lives in the array until popped; the output register is a copy of the head.
    // The read port continuously prefetches the entry behind the next head.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        data_d    = data_q;
        push      = upstr_d_valid & ready_q;
        pop       = valid_q & downstr_d_ready;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Incoming word becomes head directly when nothing else is queued ahead of it.
            if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
                data_d = upstr_data;
            end else if (pop && (count_q > CW'(1))) begin
                data_d = ram_rdata;
            end
        end

        valid_d   = (count_d != '0);
        ready_d   = !((wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                      (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]));
        af_d      = (32'(count_d) >= AF_THRESH);
        ae_d      = (32'(count_d) <= AE_THRESH);
        ram_raddr = rd_ptr_d[ADDR_W-1:0] + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            af_q     <= (AF_THRESH == 0);
            ae_q     <= 1'b1;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            data_q   <= data_d;
        end
    end

    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q[ADDR_W-1:0]),
        .wdata_i(upstr_data),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    assign upstr_d_ready   = ready_q;
    assign downstr_d_valid = valid_q;
    assign downstr_data    = data_q;
    assign count           = count_q;
    assign almost_full     = af_q;
    assign almost_empty    = ae_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench: small 8x4 instance plus a default-parameter instance for the deep fill.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit x 4 instance
    logic       rst, flush, up_valid, up_ready, dn_valid, dn_ready, af, ae;
    logic [7:0] up_data, dn_data;
    logic [2:0] count;

    // default 33 x 1024 instance
    logic        b_rst, b_flush, b_valid, b_ready, b_dvalid, b_dready, b_af, b_ae;
    logic [32:0] b_data, b_dout;
    logic [10:0] b_count;

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .upstr_d_valid(up_valid), .upstr_data(up_data), .upstr_d_ready(up_ready),
        .downstr_d_valid(dn_valid), .downstr_data(dn_data), .downstr_d_ready(dn_ready),
        .count(count), .almost_full(af), .almost_empty(ae)
    );

    sync_fifo_fwft dut_big (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .upstr_d_valid(b_valid), .upstr_data(b_data), .upstr_d_ready(b_ready),
        .downstr_d_valid(b_dvalid), .downstr_data(b_dout), .downstr_d_ready(b_dready),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pops_seen = 0;
    logic [7:0] last_pop;
    logic [7:0] exp_data;
    logic [7:0] sb [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check_eq("count",        64'(count),    64'(sb.size()));
        check_eq("dn_valid",     64'(dn_valid), 64'(sb.size() != 0));
        check_eq("up_ready",     64'(up_ready), 64'(sb.size() < 4));
        check_eq("almost_full",  64'(af),       64'(sb.size() >= 3));
        check_eq("almost_empty", 64'(ae),       64'(sb.size() <= 1));
        check_eq("dn_data",      64'(dn_data),  64'(exp_data));
    endtask

    // One clock of the small instance: score the pop, update the model, check all outputs.
    task automatic cycle();
        logic       psh, pp;
        logic [7:0] pd;
        psh = up_valid & up_ready;
        pp  = dn_valid & dn_ready;
        pd  = up_data;
        if (pp === 1'b1 && !rst && !flush) begin
            if (sb.size() == 0) begin
                check_eq("pop_empty", 64'(pp), 64'(0));
            end else begin
                check_eq("pop_data", 64'(dn_data), 64'(sb[0]));
                pops_seen++;
                last_pop = dn_data;
            end
        end
        @(posedge clk);
        #1;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (pp === 1'b1 && sb.size() != 0) void'(sb.pop_front());
            if (psh === 1'b1) sb.push_back(pd);
        end
        if (rst) exp_data = 8'h00;
        else if (sb.size() != 0) exp_data = sb[0];
        check_state();
    endtask

    task automatic drain();
        up_valid = 1'b0;
        dn_ready = 1'b1;
        for (int k = 0; k < 8 && sb.size() != 0; k++) cycle();
        check_eq("drain", 64'(sb.size()), 64'(0));
        dn_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = 8'h00; dn_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_valid = 1'b0; b_data = '0; b_dready = 1'b0;
        exp_data = 8'h00;
        cycle();
        cycle();
        rst = 1'b0;
        b_rst = 1'b0;

        // 1: single push, consumer stalled
        up_valid = 1'b1; up_data = 8'hA1;
        cycle();
        up_valid = 1'b0;
        cycle();
        drain();

        // 2: fill to full, extra word held off
        for (int v = 1; v <= 4; v++) begin
            up_valid = 1'b1; up_data = 8'(v);
            cycle();
        end
        up_data = 8'h05;
        cycle();
        cycle();

        // 3: pop while full with 0x05 offered
        dn_ready = 1'b1;
        cycle();
        check_eq("t3_count", 64'(count), 64'(3));
        dn_ready = 1'b0;
        cycle();
        check_eq("t3_accept", 64'(count), 64'(4));
        drain();

        // 4: streaming with both sides ready
        p0 = pops_seen;
        dn_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            up_valid = 1'b1; up_data = 8'(i);
            cycle();
            check_eq("t4_count_le1", 64'(count <= 3'd1), 64'(1));
        end
        up_valid = 1'b0;
        cycle();
        check_eq("t4_pops", 64'(pops_seen - p0), 64'(16));
        dn_ready = 1'b0;

        // 5: flush with a push in the same cycle
        for (int v = 0; v < 3; v++) begin
            up_valid = 1'b1; up_data = 8'(8'h31 + v);
            cycle();
        end
        flush = 1'b1; up_data = 8'h77;
        cycle();
        flush = 1'b0; up_data = 8'h88;
        cycle();
        up_valid = 1'b0; dn_ready = 1'b1;
        cycle();
        check_eq("t5_first", 64'(last_pop), 64'(8'h88));
        drain();

        // 6: mid-stream reset with traffic offered
        for (int v = 0; v < 2; v++) begin
            up_valid = 1'b1; up_data = 8'(8'hC0 + v);
            cycle();
        end
        rst = 1'b1; up_data = 8'hC7;
        cycle();
        rst = 1'b0; up_valid = 1'b0;
        cycle();

        // 6b: deep fill of the default-parameter instance
        check_eq("big_rst_ready", 64'(b_ready), 64'(1));
        check_eq("big_rst_count", 64'(b_count), 64'(0));
        b_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            b_data = 33'h1_0000_0000 | 33'(i * 3);
            @(posedge clk);
            #1;
            if (i == 1022) begin
                check_eq("big_ready_1023", 64'(b_ready), 64'(1));
                check_eq("big_count_1023", 64'(b_count), 64'(1023));
            end
        end
        b_valid = 1'b0;
        check_eq("big_count_full", 64'(b_count), 64'(1024));
        check_eq("big_ready_full", 64'(b_ready), 64'(0));
        check_eq("big_af_full",    64'(b_af),    64'(1));
        check_eq("big_head",       64'(b_dout),  64'(33'h1_0000_0000));
        b_dready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("big_pop1_data",  64'(b_dout),  64'(33'h1_0000_0003));
        check_eq("big_pop1_ready", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1;
        check_eq("big_pop2_data",  64'(b_dout),  64'(33'h1_0000_0006));
        check_eq("big_pop2_count", 64'(b_count), 64'(1022));
        b_dready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
